rmii_rx_deser: RTL

RMII_RX_DESER -- requirements
Module: rmii_rx_deser

---
 rtl/rmii_pkg.sv | 15 +
 rtl/rmii_dibit_sampler.sv | 42 ++++
 rtl/rmii_rx_deser.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rmii_pkg.sv
// Shared types and constants for the RMII receive deserializer.
package rmii_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    ABORT    = 2'd3
  } rx_state_e;

  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;
  localparam int         DIV_10M   = 10;

endpackage

// File: rtl/rmii_dibit_sampler.sv
// Dibit sample strobe. With RMII_RX_10M_EN defined, speed_10_i=1 strobes on the
// first data_valid-high cycle out of idle and every DIV_10M cycles after that.
module rmii_dibit_sampler
  import rmii_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic idle_i,
  input  logic data_valid_i,
  input  logic speed_10_i,
  output logic sample_o
);

`ifdef RMII_RX_10M_EN
  localparam int CW = $clog2(DIV_10M);

  logic [CW-1:0] div_q;

  // Idle keeps the phase at zero so the first data_valid-high cycle is a sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (!speed_10_i) begin
      div_q <= '0;
    end else if (idle_i) begin
      div_q <= data_valid_i ? CW'(1) : '0;
    end else if (div_q == CW'(DIV_10M - 1)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign sample_o = !speed_10_i || idle_i || (div_q == '0);
`else
  logic unused_in;

  assign unused_in = ^{clk, reset, idle_i, data_valid_i, speed_10_i};
  assign sample_o  = 1'b1;
`endif

endmodule

// File: rtl/rmii_rx_deser.sv
// RMII receive dibit deserializer: preamble/SFD detect, byte assembly, word packing.
// Optional 10 Mb/s sampling is built when RMII_RX_10M_EN is defined.
//
// state    | meaning
// IDLE     | waiting for data_valid
// PREAMBLE | counting 01 dibits, waiting for SFD
// DATA     | assembling bytes, packing and emitting words
// ABORT    | bad preamble or oversize frame; ignore until data_valid low
module rmii_rx_deser
  import rmii_pkg::*;
#(
  parameter int OUT_BYTES    = 1,
  parameter int MIN_PREAMBLE = 8,
  parameter int MAX_FRAME    = 1522
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   data_valid,
  input  logic                   rx0,
  input  logic                   rx1,
  input  logic                   speed_10,
  output logic [8*OUT_BYTES-1:0] rx_data,
  output logic [OUT_BYTES-1:0]   rx_keep,
  output logic                   rx_valid,
  output logic                   rx_sof,
  output logic                   rx_eof,
  output logic                   rx_err
);

  localparam int LW = $clog2(OUT_BYTES + 1);
  localparam int PW = $clog2(MIN_PREAMBLE + 1);
  localparam int BW = $clog2(MAX_FRAME + 1) + 1;

  rx_state_e              state_q;
  logic [PW-1:0]          pre_cnt_q;
  logic [5:0]             dib_sr_q;
  logic [1:0]             dib_cnt_q;
  logic [8*OUT_BYTES-1:0] word_q;
  logic [LW-1:0]          lane_cnt_q;
  logic [BW-1:0]          byte_cnt_q;
  logic                   first_q;

  logic [8*OUT_BYTES-1:0] rx_data_q;
  logic [OUT_BYTES-1:0]   rx_keep_q;
  logic                   rx_valid_q, rx_sof_q, rx_eof_q, rx_err_q;

  logic                   sample;
  logic [1:0]             dibit;
  logic                   dv_hi, dv_lo;
  logic [7:0]             byte_new;
  logic                   word_full;
  logic                   frame_at_max;
  logic [OUT_BYTES-1:0]   keep_cur;

  rmii_dibit_sampler u_sampler (
    .clk          (clk),
    .reset        (reset),
    .idle_i       (state_q == IDLE),
    .data_valid_i (data_valid),
    .speed_10_i   (speed_10),
    .sample_o     (sample)
  );

  assign dibit        = {rx1, rx0};
  assign dv_hi        = sample && data_valid;
  assign dv_lo        = sample && !data_valid;
  assign byte_new     = {dibit, dib_sr_q};
  assign word_full    = (lane_cnt_q == LW'(OUT_BYTES));
  assign frame_at_max = (byte_cnt_q >= BW'(MAX_FRAME));

  always_comb begin
    keep_cur = '0;
    for (int k = 0; k < OUT_BYTES; k++) begin
      keep_cur[k] = (k < int'(lane_cnt_q));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      dib_sr_q   <= '0;
      dib_cnt_q  <= '0;
      word_q     <= '0;
      lane_cnt_q <= '0;
      byte_cnt_q <= '0;
      first_q    <= 1'b0;
      rx_data_q  <= '0;
      rx_keep_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_sof_q   <= 1'b0;
      rx_eof_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_data_q  <= '0;
      rx_keep_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_sof_q   <= 1'b0;
      rx_eof_q   <= 1'b0;
      rx_err_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          // The rising cycle's dibit already counts toward the preamble.
          if (dv_hi) begin
            state_q   <= PREAMBLE;
            pre_cnt_q <= (dibit == PRE_DIBIT) ? PW'(1) : '0;
          end
        end

        PREAMBLE: begin
          if (dv_lo) begin
            state_q <= IDLE;
          end else if (dv_hi) begin
            if (dibit == PRE_DIBIT) begin
              if (pre_cnt_q < PW'(MIN_PREAMBLE)) pre_cnt_q <= pre_cnt_q + 1'b1;
            end else if (dibit == SFD_DIBIT && pre_cnt_q >= PW'(MIN_PREAMBLE)) begin
              state_q    <= DATA;
              dib_sr_q   <= '0;
              dib_cnt_q  <= '0;
              word_q     <= '0;
              lane_cnt_q <= '0;
              byte_cnt_q <= '0;
              first_q    <= 1'b1;
            end else begin
              state_q <= ABORT;
            end
          end
        end

        DATA: begin
          if (dv_lo) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= word_q;
            rx_keep_q  <= keep_cur;
            rx_sof_q   <= first_q;
            rx_eof_q   <= 1'b1;
            rx_err_q   <= (dib_cnt_q != 2'd0) || (byte_cnt_q == '0);
            state_q    <= IDLE;
          end else if (dv_hi) begin
            if (frame_at_max) begin
              // Data beyond MAX_FRAME bytes: close the frame with an error.
              rx_valid_q <= 1'b1;
              rx_data_q  <= word_q;
              rx_keep_q  <= keep_cur;
              rx_sof_q   <= first_q;
              rx_eof_q   <= 1'b1;
              rx_err_q   <= 1'b1;
              state_q    <= ABORT;
            end else begin
              if (word_full) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= word_q;
                rx_keep_q  <= keep_cur;
                rx_sof_q   <= first_q;
                first_q    <= 1'b0;
                word_q     <= '0;
                lane_cnt_q <= '0;
              end
              dib_sr_q  <= {dibit, dib_sr_q[5:2]};
              dib_cnt_q <= dib_cnt_q + 1'b1;
              // A full word always sits on a byte boundary, so this never
              // coincides with the flush above.
              if (dib_cnt_q == 2'd3) begin
                word_q[int'(lane_cnt_q)*8 +: 8] <= byte_new;
                lane_cnt_q <= lane_cnt_q + 1'b1;
                byte_cnt_q <= byte_cnt_q + 1'b1;
              end
            end
          end
        end

        ABORT: begin
          if (dv_lo) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_keep  = rx_keep_q;
  assign rx_valid = rx_valid_q;
  assign rx_sof   = rx_sof_q;
  assign rx_eof   = rx_eof_q;
  assign rx_err   = rx_err_q;

endmodule
